updown_counter: RTL and testbench

Parametrised up/down counter with programmable bounds, step size, parallel load and wrap/saturate mode, plus a terminal-count pulse and a sticky overflow flag. It is the general-purpose successor to the basic enable/clear/wrap counter and is used for timers, address generators and event counting across the design. An optional prescaler divides the advance rate without a separate divider block.

---
 rtl/updown_counter_if.sv | 36 +++
 rtl/updown_counter.sv | 103 ++++++++++
 tb/tb_updown_counter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// Control, bound and status signals of updown_counter, bundled for port hookup.
// Latency: none; wires only.
// Backpressure: none; the counter accepts a new command every cycle.
interface updown_counter_if #(
  parameter int N     = 8,
  parameter int PRE_W = 4
);
  logic             clear;
  logic             load;
  logic [N-1:0]     load_val;
  logic             en;
  logic             dir;
  logic             wrap;
  logic [N-1:0]     min_val;
  logic [N-1:0]     max_val;
  logic [N-1:0]     step;
  logic [PRE_W-1:0] prescale;
  logic             ack_ovf;
  logic [N-1:0]     count;
  logic             at_max;
  logic             at_min;
  logic             tc;
  logic             ovf;

  modport master (
    output clear, load, load_val, en, dir, wrap,
    output min_val, max_val, step, prescale, ack_ovf,
    input  count, at_max, at_min, tc, ovf
  );

  modport slave (
    input  clear, load, load_val, en, dir, wrap,
    input  min_val, max_val, step, prescale, ack_ovf,
    output count, at_max, at_min, tc, ovf
  );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter: programmable bounds/step, load, wrap or saturate, tc pulse, sticky ovf.
// Latency: count/tc/ovf one cycle after the qualifying inputs; at_max/at_min combinational.
// Backpressure: none; optional prescaler via UPDOWN_COUNTER_PRESCALE_EN slows the advance rate.
module updown_counter #(
  parameter int N     = 8,
  parameter int PRE_W = 4
) (
  input  logic               clk,
  input  logic               nrst,
  updown_counter_if.slave    bus
);

  logic [N-1:0] count_q;
  logic         tc_q;
  logic         ovf_q;
  logic         tick;
  logic [N:0]   sum_up;
  logic [N:0]   lim_dn;
  logic         hit;
  logic         advance;
  logic         bound_evt;
  logic [N-1:0] count_nxt;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;

  assign tick = bus.en && (pre_q == bus.prescale);

  // Prescaler: counts enabled cycles 0..prescale, restarts on clear/load, frozen while en is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre_q <= '0;
    end else if (bus.clear || bus.load) begin
      pre_q <= '0;
    end else if (bus.en) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end
`else
  logic unused_prescale;

  assign tick            = bus.en;
  assign unused_prescale = ^bus.prescale;
`endif

  // Inverted bounds disable advancing entirely, so tc/ovf cannot fire either.
  assign advance = tick && (bus.min_val <= bus.max_val);
  // Widened sums so neither direction can silently wrap through zero or 2^N.
  assign sum_up  = {1'b0, count_q} + {1'b0, bus.step};
  assign lim_dn  = {1'b0, bus.min_val} + {1'b0, bus.step};

  // Bound detection and the next count value for an advance.
  always_comb begin
    hit       = 1'b0;
    count_nxt = count_q;
    if (bus.dir) begin
      hit       = sum_up > {1'b0, bus.max_val};
      count_nxt = hit ? (bus.wrap ? bus.min_val : bus.max_val) : sum_up[N-1:0];
    end else begin
      hit       = {1'b0, count_q} < lim_dn;
      count_nxt = hit ? (bus.wrap ? bus.max_val : bus.min_val) : count_q - bus.step;
    end
  end

  assign bound_evt = advance && hit && !bus.clear && !bus.load;

  // Count register and one-cycle terminal-count pulse; clear beats load beats advance.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      tc_q    <= 1'b0;
    end else begin
      if (advance) begin
        count_q <= count_nxt;
      end
      tc_q <= bound_evt;
    end
  end

  // Sticky overflow: a new bound event wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= 1'b0;
    end else if (bound_evt) begin
      ovf_q <= 1'b1;
    end else if (bus.ack_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.at_max = (count_q == bus.max_val);
  assign bus.at_min = (count_q == bus.min_val);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: vector table, hand sequences, randomized model compare.
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next edge.
// Backpressure: none; prescaler sequence runs only when UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_counter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  updown_counter_if #(.N(8), .PRE_W(4)) bus ();

  updown_counter #(.N(8), .PRE_W(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state held as plain integers.
  int m_cnt, m_pre;
  bit m_tc, m_ovf;

  typedef struct {
    bit       clr, ld;
    bit [7:0] lv;
    bit       en, dir, wrap;
    bit [7:0] mn, mx, st;
    bit       ack;
    int       ec;
    bit       etc, eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
  endtask

  // Apply the counter rules to the inputs currently driven.
  task automatic model_step();
    bit t, evt;
    int mn, mx, st;
    mn = bus.min_val; mx = bus.max_val; st = bus.step;
    evt = 0;
    if (bus.clear) begin
      m_cnt = 0; m_pre = 0; m_tc = 0;
    end else if (bus.load) begin
      m_cnt = bus.load_val; m_pre = 0; m_tc = 0;
    end else begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      t = bus.en && (m_pre == int'(bus.prescale));
      if (bus.en) m_pre = t ? 0 : m_pre + 1;
`else
      t = bus.en;
`endif
      if (t && mn <= mx) begin
        if (bus.dir) begin
          if (m_cnt + st > mx) begin evt = 1; m_cnt = bus.wrap ? mn : mx; end
          else m_cnt = m_cnt + st;
        end else begin
          if (m_cnt - st < mn) begin evt = 1; m_cnt = bus.wrap ? mx : mn; end
          else m_cnt = m_cnt - st;
        end
      end
      m_tc = evt;
    end
    if (evt) m_ovf = 1;
    else if (bus.ack_ovf) m_ovf = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.clear = v.clr; bus.load = v.ld; bus.load_val = v.lv;
    bus.en = v.en; bus.dir = v.dir; bus.wrap = v.wrap;
    bus.min_val = v.mn; bus.max_val = v.mx; bus.step = v.st;
    bus.ack_ovf = v.ack; bus.prescale = '0;
  endtask

  function automatic vec_t mkv(bit clr, bit ld, bit [7:0] lv, bit en, bit dir, bit wrap,
                               bit [7:0] mn, bit [7:0] mx, bit [7:0] st, bit ack,
                               int ec, bit etc, bit eovf);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.dir = dir; v.wrap = wrap;
    v.mn = mn; v.mx = mx; v.st = st; v.ack = ack; v.ec = ec; v.etc = etc; v.eovf = eovf;
    return v;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_count"},  int'(bus.count),  m_cnt);
    check({tag, "_tc"},     int'(bus.tc),     int'(m_tc));
    check({tag, "_ovf"},    int'(bus.ovf),    int'(m_ovf));
    check({tag, "_at_max"}, int'(bus.at_max), int'(m_cnt == int'(bus.max_val)));
    check({tag, "_at_min"}, int'(bus.at_min), int'(m_cnt == int'(bus.min_val)));
  endtask

  initial begin
    // Rows: clr ld lv en dir wrap mn mx st ack | count tc ovf
    tbl.push_back(mkv(0,1, 0,0,1,0, 0,10,3,1,  0,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,0, 0,10,3,0,  3,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,0, 0,10,3,0,  6,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,0, 0,10,3,0,  9,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,0, 0,10,3,0, 10,1,1));
    tbl.push_back(mkv(0,0, 0,1,1,0, 0,10,3,0, 10,1,1));
    tbl.push_back(mkv(0,1, 7,0,0,1, 5,20,4,0,  7,0,1));
    tbl.push_back(mkv(0,0, 0,1,0,1, 5,20,4,0, 20,1,1));
    tbl.push_back(mkv(0,0, 0,1,0,1, 5,20,4,0, 16,0,1));
    tbl.push_back(mkv(0,0, 0,0,0,1, 5,20,4,1, 16,0,0));
    tbl.push_back(mkv(1,1,33,0,0,1, 5,20,4,0,  0,0,0));
    tbl.push_back(mkv(0,0, 0,1,0,1, 5,20,4,0, 20,1,1));
    tbl.push_back(mkv(0,0, 0,1,1,0, 5,20,4,1, 20,1,1));
    tbl.push_back(mkv(0,0, 0,0,1,0, 5,20,4,1, 20,0,0));
    tbl.push_back(mkv(0,1,25,0,1,0, 5,20,0,0, 25,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,0, 5,20,0,0, 20,1,1));
    tbl.push_back(mkv(0,0, 0,1,1,0, 5,20,0,0, 20,0,1));
    tbl.push_back(mkv(0,0, 0,0,1,0, 5,20,0,1, 20,0,0));
    tbl.push_back(mkv(0,1, 8,0,1,1, 2,10,5,0,  8,0,0));
    tbl.push_back(mkv(0,0, 0,1,1,1, 2,10,5,0,  2,1,1));
    tbl.push_back(mkv(0,1, 2,0,0,0, 0,10,5,0,  2,0,1));
    tbl.push_back(mkv(0,0, 0,1,0,0, 0,10,5,0,  0,1,1));
    tbl.push_back(mkv(0,0, 0,1,0,0, 0,10,0,0,  0,0,1));

    // Reset state.
    drive(mkv(0,0,0,0,1,1,0,9,1,0,0,0,0));
    model_reset();
    #2;
    check("reset_count", int'(bus.count), 0);
    check("reset_tc", int'(bus.tc), 0);
    check("reset_ovf", int'(bus.ovf), 0);
    check("reset_at_min", int'(bus.at_min), 1);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Wrap sequence 0..9 then 0.
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("wrap_count", int'(bus.count), i % 10);
      check("wrap_tc", int'(bus.tc), int'(i == 10));
      check("wrap_ovf", int'(bus.ovf), int'(i == 10));
      if (i == 9) check("wrap_at_max", int'(bus.at_max), 1);
    end

    // Vector table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
      check($sformatf("vec%0d_count", i), int'(bus.count), tbl[i].ec);
      check($sformatf("vec%0d_tc", i), int'(bus.tc), int'(tbl[i].etc));
      check($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(tbl[i].eovf));
    end

    // Inverted bounds: nothing moves.
    drive(mkv(0,0,0,1,1,1,8,4,1,0,0,0,0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("inv_count", int'(bus.count), 0);
      check("inv_tc", int'(bus.tc), 0);
      check("inv_ovf", int'(bus.ovf), 1);
    end

    // Asynchronous reset mid-count with ovf set.
    drive(mkv(0,0,0,1,1,1,0,200,1,0,0,0,0));
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_count", int'(bus.count), 3);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check("arst_count", int'(bus.count), 0);
    check("arst_tc", int'(bus.tc), 0);
    check("arst_ovf", int'(bus.ovf), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // Prescaler: one advance per three enabled cycles, frozen while en is low.
    drive(mkv(1,0,0,0,1,1,0,100,1,0,0,0,0));
    tick();
    bus.clear = 1'b0; bus.en = 1'b1; bus.prescale = 4'd2;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("pre_count", int'(bus.count), i / 3);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pre_hold", int'(bus.count), 2);
    end
    bus.en = 1'b1;
    tick();
    check("pre_resume1", int'(bus.count), 2);
    tick();
    check("pre_resume2", int'(bus.count), 3);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        bus.min_val = 8'($urandom_range(0, 40));
        bus.max_val = 8'($urandom_range(0, 60));
        bus.step    = 8'($urandom_range(0, 7));
        bus.prescale = 4'($urandom_range(0, 3));
      end
      bus.clear    = ($urandom_range(0, 39) == 0);
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = 8'($urandom_range(0, 80));
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.dir      = 1'($urandom);
      bus.wrap     = 1'($urandom);
      bus.ack_ovf  = ($urandom_range(0, 7) == 0);
      tick();
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
